// File: rtl/cash_pkg.sv
// Shared types, default sizes and the free-slot priority encoder for the cash data array.
package cash_pkg;
  localparam int CASH_DATA_WIDTH = 32;
  localparam int CASH_MEM_SIZE   = 128;
  localparam int CASH_MAX_CELLS  = 1024;
  localparam int CASH_MAX_IDX_W  = 10;

  typedef struct packed {
    logic [CASH_DATA_WIDTH-1:0] data;
    logic                       valid;
    logic                       parity;
  } cash_cell_t;

  typedef struct packed {
    logic                      found;
    logic [CASH_MAX_IDX_W-1:0] idx;
  } cash_pe_t;

  // Lowest set bit wins; callers zero-extend their free mask to CASH_MAX_CELLS.
  function automatic cash_pe_t cash_lowest_free(input logic [CASH_MAX_CELLS-1:0] free);
    cash_pe_t r;
    r = '0;
    for (int i = CASH_MAX_CELLS-1; i >= 0; i--) begin
      if (free[i]) begin
        r.found = 1'b1;
        r.idx   = CASH_MAX_IDX_W'(i);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/cash_data_array_cell.sv
// One storage cell: data, valid and optional parity with del > we > insert resolution.
// Optional feature: CASH_DATA_PARITY_EN.
module cash_valid_cell
  import cash_pkg::*;
#(
  parameter int DATA_WIDTH = CASH_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_del,
  input  logic                  i_we,
  input  logic                  i_ins,
  input  logic                  i_par_inject,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [DATA_WIDTH-1:0] i_ins_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_valid_nxt,
  output logic                  o_parity
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  parity;
  } cell_t;

  cell_t                 r_cell;
  cell_t                 w_nxt;
  logic [DATA_WIDTH-1:0] w_wdata;

  always_comb begin
    w_nxt   = r_cell;
    w_wdata = i_we ? i_wr_data : i_ins_data;
    if (i_del) begin
      w_nxt.valid = 1'b0;
    end else if (i_we || i_ins) begin
      w_nxt.data  = w_wdata;
      w_nxt.valid = 1'b1;
`ifdef CASH_DATA_PARITY_EN
      w_nxt.parity = (^w_wdata) ^ i_par_inject;
`endif
    end
  end

`ifndef CASH_DATA_PARITY_EN
  logic w_unused_par;
  assign w_unused_par = i_par_inject;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_cell <= '0;
    else         r_cell <= w_nxt;
  end

  assign o_data      = r_cell.data;
  assign o_valid     = r_cell.valid;
  assign o_valid_nxt = w_nxt.valid;
  assign o_parity    = r_cell.parity;
endmodule

// File: rtl/cash_data_array.sv
// Hash-table cache storage: auto-insert into lowest free slot, direct write, delete, 1-cycle read.
// Optional feature: CASH_DATA_PARITY_EN (per-cell parity and rd_perr).
module cash_data_array
  import cash_pkg::*;
#(
  parameter  int DATA_WIDTH = CASH_DATA_WIDTH,
  parameter  int MEM_SIZE   = CASH_MEM_SIZE,
  localparam int IDX_W      = $clog2(MEM_SIZE)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_cs,
  input  logic                           i_ins_valid,
  input  logic [DATA_WIDTH-1:0]          i_ins_data,
  output logic                           o_ins_ready,
  output logic                           o_ins_done,
  output logic [IDX_W-1:0]               o_ins_idx,
  input  logic [MEM_SIZE-1:0]            i_we,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic [MEM_SIZE-1:0]            i_del,
  input  logic                           i_par_inject,
  input  logic                           i_rd_en,
  input  logic [IDX_W-1:0]               i_rd_idx,
  output logic                           o_rd_vld,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output logic                           o_rd_hit,
  output logic                           o_rd_perr,
  output logic [MEM_SIZE*DATA_WIDTH-1:0] o_data_out,
  output logic [MEM_SIZE-1:0]            o_valid_out,
  output logic [IDX_W:0]                 o_count,
  output logic                           o_full,
  output logic                           o_empty
);
  logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] w_data;
  logic [MEM_SIZE-1:0] w_valid, w_valid_nxt, w_par, w_free, w_ins_sel, w_we, w_del;
  cash_pe_t            w_pe;
  logic [IDX_W-1:0]    w_slot;
  logic                w_ins_acc, w_rd_inrange, w_unused_pe;
  logic [IDX_W:0]      w_cnt_nxt;

  logic                  r_ins_done, r_rd_vld, r_rd_hit, r_full, r_empty;
  logic [IDX_W-1:0]      r_ins_idx;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [IDX_W:0]        r_count;

  assign w_we   = i_cs ? i_we  : '0;
  assign w_del  = i_cs ? i_del : '0;
  // A cell being directly written this cycle is not a candidate for insert.
  assign w_free = ~w_valid & ~w_we;
  assign w_pe   = cash_lowest_free(CASH_MAX_CELLS'(w_free));
  assign w_slot = w_pe.idx[IDX_W-1:0];
  assign w_unused_pe = ^w_pe.idx;

  assign o_ins_ready = i_cs & w_pe.found;
  assign w_ins_acc   = i_ins_valid & o_ins_ready;

  for (genvar g = 0; g < MEM_SIZE; g++) begin : g_cell
    assign w_ins_sel[g] = w_ins_acc && (w_slot == IDX_W'(g));
    cash_valid_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_del        (w_del[g]),
      .i_we         (w_we[g]),
      .i_ins        (w_ins_sel[g]),
      .i_par_inject (i_par_inject),
      .i_wr_data    (i_wr_data),
      .i_ins_data   (i_ins_data),
      .o_data       (w_data[g]),
      .o_valid      (w_valid[g]),
      .o_valid_nxt  (w_valid_nxt[g]),
      .o_parity     (w_par[g])
    );
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < MEM_SIZE; i++) w_cnt_nxt = w_cnt_nxt + (IDX_W+1)'(w_valid_nxt[i]);
  end

  if (MEM_SIZE == (1 << IDX_W)) begin : g_pow2
    assign w_rd_inrange = 1'b1;
  end else begin : g_npow2
    assign w_rd_inrange = ({1'b0, i_rd_idx} < (IDX_W+1)'(MEM_SIZE));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ins_done <= 1'b0;
      r_ins_idx  <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_vld   <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ins_done <= w_ins_acc;
      if (w_ins_acc) r_ins_idx <= w_slot;
      r_count    <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == (IDX_W+1)'(MEM_SIZE));
      r_empty    <= (w_cnt_nxt == '0);
      r_rd_vld   <= i_rd_en;
      if (i_rd_en) begin
        r_rd_hit  <= w_rd_inrange ? w_valid[i_rd_idx] : 1'b0;
        r_rd_data <= w_rd_inrange ? w_data[i_rd_idx]  : '0;
      end
    end
  end

`ifdef CASH_DATA_PARITY_EN
  logic r_rd_perr;
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_rd_perr <= 1'b0;
    else if (i_rd_en) r_rd_perr <= w_rd_inrange && w_valid[i_rd_idx] &&
                                   (w_par[i_rd_idx] != ^w_data[i_rd_idx]);
  end
  assign o_rd_perr = r_rd_perr;
`else
  logic w_unused_par;
  assign w_unused_par = ^w_par;
  assign o_rd_perr    = 1'b0;
`endif

  assign o_ins_done  = r_ins_done;
  assign o_ins_idx   = r_ins_idx;
  assign o_rd_vld    = r_rd_vld;
  assign o_rd_data   = r_rd_data;
  assign o_rd_hit    = r_rd_hit;
  assign o_data_out  = w_data;
  assign o_valid_out = w_valid;
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
endmodule

// File: doc/cash_data_array.md
# cash_data_array

Parametrised storage array for the hash-table cache: MEM_SIZE cells of DATA_WIDTH bits, each with its own valid bit. Supports automatic insert into the lowest free slot, direct per-cell overwrite, per-cell delete and a registered indexed read port. Keeps occupancy count and full/empty flags for the hash-table controller, and still exposes the full parallel cell contents for match logic.

## Interface
- DATA_WIDTH, 32, bits per cell
- MEM_SIZE, 128, number of cells (≥2)
- IDX_W, $clog2(MEM_SIZE), derived localparam, not overridable
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cs  in  1  chip select; gates insert, we and del
- ins_valid  in  1  insert request
- ins_data  in  DATA_WIDTH  insert payload
- ins_ready  out  1  combinational: cs and a free, non-overwritten slot exists
- ins_done  out  1  registered pulse, one cycle after accepted insert
- ins_idx  out  IDX_W  slot used by last accepted insert; held until next insert
- we  in  MEM_SIZE  per-cell direct write enable; sets valid
- wr_data  in  DATA_WIDTH  data for direct writes
- del  in  MEM_SIZE  per-cell delete; clears valid
- par_inject  in  1  test hook: invert stored parity on every write this cycle
- rd_en  in  1  read request
- rd_idx  in  IDX_W  read index
- rd_vld  out  1  registered pulse, one cycle after rd_en
- rd_data  out  DATA_WIDTH  cell data at time of rd_en
- rd_hit  out  1  cell valid bit at time of rd_en
- rd_perr  out  1  parity mismatch on read
- data_out  out  MEM_SIZE×DATA_WIDTH  current cell registers, unmasked
- valid_out  out  MEM_SIZE  current valid bits
- count  out  IDX_W+1  number of valid cells
- full, empty  out  1 each  count==MEM_SIZE / count==0

## Operation
- Accepted insert: ins_valid & ins_ready. Slot = lowest index i with ~valid[i] & ~(cs & we[i]). Cell i gets ins_data, valid set.
- Direct write: cs & we[i] stores wr_data and sets valid[i], regardless of prior valid state.
- Delete: cs & del[i] clears valid[i]; data register is untouched.
- Same-cell priority in one cycle: del > we > insert. Insert never targets a cell with we set. del on an invalid cell is a no-op.
- A delete frees its slot for insert from the next cycle only.
- Out-of-range rd_idx (≥MEM_SIZE): rd_vld pulses with rd_hit=0, rd_data=0, rd_perr=0.
- cs low: no state change except the read path. Reads ignore cs.
- count, full and empty are registered on the same edge as valid. count always equals popcount(valid_out).

## Timing
- Reset values: all data regs 0, valid 0, count 0, empty 1, full 0, ins_done 0, ins_idx 0, rd_vld/rd_hit/rd_perr 0, rd_data 0. ins_ready=cs after reset.
- Insert: the cell, valid bit and count update at edge N. ins_done/ins_idx are valid in cycle N+1.
- Read latency is 1 cycle, read-before-write. A same-cycle write or delete to rd_idx is not visible in that read. Back-to-back reads are allowed every cycle.
- Reset asserted mid-operation aborts everything. Pending ins_done/rd_vld pulses are dropped.
- Inserts and direct writes to different cells complete in the same cycle.

## Configuration
- CASH_DATA_PARITY_EN defined: each cell stores an even-parity bit computed at every write (insert or we), inverted when par_inject=1. rd_perr = stored parity ≠ ^rd_data for valid, in-range reads.
- Undefined: no parity storage. rd_perr is tied 0, par_inject is ignored. Port list is unchanged.

## Structure
- Package cash_pkg holds:
  - cell typedef struct {data, valid, parity}
  - default DATA_WIDTH/MEM_SIZE constants
  - the priority-encoder function for free-slot search
- Sub-module cash_valid_cell: one cell with data, valid and optional parity register, plus del/we/ins resolution. It is instantiated MEM_SIZE times in a generate loop.

## Test plan
- Reset, then 3 inserts of 0xA0,0xA1,0xA2 with cs=1 -> ins_idx 0,1,2 on successive ins_done; count=3; rd_idx=1 gives rd_data=0xA1, rd_hit=1 one cycle later.
- Fill all MEM_SIZE cells -> full=1, ins_ready=0. del[5] -> next cycle full=0. Next insert lands at idx 5.
- Same cycle: insert with valid[0]=0, we[0]=1 wr_data=0x55 -> cell0=0x55, insert goes to cell 1. Then del[1]&we[1] together -> valid[1]=0.
- rd_en on cell 2 while del[2] is asserted -> rd_hit=1 with old data; a read next cycle gives rd_hit=0. count is decremented by 1.
- With CASH_DATA_PARITY_EN: write 0x3 with par_inject=1, then read -> rd_perr=1. Rewrite with par_inject=0 -> rd_perr=0. Without the macro rd_perr stays 0.
- cs=0 with ins_valid, we=all-ones, del=all-ones -> no state change, ins_ready=0. Reset asserted during an insert -> count=0, ins_done stays 0.
